// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: N-channel cacheline request arbiter feeding one adaptor port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module cacheline_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic                     mem_resp,
    input  logic [LINE_W-1:0]        mem_rdata,
    output logic                     busy,
    output logic [CH_W-1:0]          grant_ch
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    logic [0:0]        state;
    logic              op_read;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [NUM_CH-1:0] pending;
    logic              found;
    logic [CH_W-1:0]   win;
    int                idx;
`ifdef ARB_ROUND_ROBIN_EN
    logic [CH_W-1:0]   ptr;
`endif
    assign pending = ch_read | ch_write;
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = 0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            idx = (int'(ptr) + i) % NUM_CH;
`else
            idx = i;
`endif
            if (!found && pending[idx]) begin
                found = 1'b1;
                win = CH_W'(idx);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_read <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            grant_ch <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                state <= BUSY;
                op_read <= ch_read[win];
                addr_q <= ch_addr[int'(win)*ADDR_W +: ADDR_W];
                wdata_q <= ch_read[win] ? '0 : ch_wdata[int'(win)*LINE_W +: LINE_W];
                grant_ch <= win;
            end
        end else if (mem_resp) begin
            state <= IDLE;
        end
    end
`ifdef ARB_ROUND_ROBIN_EN
    // Pointer advances past each winner so the search starts at the next channel.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (state == IDLE && found)
            ptr <= (int'(win) == NUM_CH - 1) ? '0 : win + 1'b1;
    end
`endif
    assign busy      = (state == BUSY);
    assign mem_read  = busy && op_read;
    assign mem_write = busy && !op_read;
    assign mem_addr  = busy ? addr_q : '0;
    assign mem_wdata = busy ? wdata_q : '0;
    assign ch_resp   = (busy && mem_resp) ? (NUM_CH'(1) << grant_ch) : '0;
    assign ch_rdata  = (busy && op_read) ? mem_rdata : '0;
endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: directed self-checking bench for a 4-channel cacheline_arbiter.
// Expected grant order follows ARB_ROUND_ROBIN_EN when it is defined.
module tb_cacheline_arbiter;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        ch_read;
    logic [NUM_CH-1:0]        ch_write;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*LINE_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_resp;
    logic [LINE_W-1:0]        ch_rdata;
    logic                     mem_read;
    logic                     mem_write;
    logic [ADDR_W-1:0]        mem_addr;
    logic [LINE_W-1:0]        mem_wdata;
    logic                     mem_resp;
    logic [LINE_W-1:0]        mem_rdata;
    logic                     busy;
    logic [1:0]               grant_ch;
    int checks = 0;
    int errors = 0;
    logic [LINE_W-1:0] a5 = {(LINE_W/8){8'hA5}};

    cacheline_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst), .ch_read(ch_read), .ch_write(ch_write),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_resp(ch_resp), .ch_rdata(ch_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .busy(busy), .grant_ch(grant_ch)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ch_read = '0; ch_write = '0; ch_addr = '0; ch_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        apply_reset();
        @(negedge clk);
        checks++;
        if ({busy, mem_read, mem_write, ch_resp} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/rd/wr/resp %b required 0", {busy, mem_read, mem_write, ch_resp});
        end
        checks++;
        if (grant_ch !== 2'd0 || mem_addr !== '0 || mem_wdata !== '0 || ch_rdata !== '0) begin
            errors++;
            $display("FAIL reset_data: got grant %0d addr %h required 0", grant_ch, mem_addr);
        end
    endtask

    task automatic test_single_read();
        step();
        ch_read = 4'b0010;
        ch_addr[1*ADDR_W +: ADDR_W] = 32'h0000_1000;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL read_latency: got busy %b required 0", busy);
        end
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 5) begin mem_resp = 1'b1; mem_rdata = a5; end
            @(negedge clk);
            checks++;
            if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h1000 || grant_ch !== 2'd1) begin
                errors++;
                $display("FAIL read_busy c%0d: got rd %b wr %b addr %h grant %0d required 1 0 1000 1", c, mem_read, mem_write, mem_addr, grant_ch);
            end
            checks++;
            if (ch_resp !== (c == 5 ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("FAIL read_resp c%0d: got %b required %b", c, ch_resp, (c == 5 ? 4'b0010 : 4'b0000));
            end
        end
        checks++;
        if (ch_rdata !== a5) begin
            errors++;
            $display("FAIL read_rdata: got %h required %h", ch_rdata, a5);
        end
        step();
        mem_resp = 1'b0; mem_rdata = '0; ch_read = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_read !== 1'b0 || ch_resp !== 4'b0) begin
            errors++;
            $display("FAIL read_done: got busy %b rd %b resp %b required 0 0 0", busy, mem_read, ch_resp);
        end
    endtask

    task automatic test_write_capture();
        ch_write = 4'b0001;
        ch_addr[0 +: ADDR_W] = 32'h40;
        ch_wdata[0 +: LINE_W] = 256'h1234;
        for (int c = 1; c <= 3; c++) begin
            step();
            ch_addr = {4{32'hDEAD_BEEF}};
            ch_wdata = {32{32'hCAFE_F00D}};
            mem_rdata = a5;
            if (c == 3) mem_resp = 1'b1;
            @(negedge clk);
            checks++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h40 || mem_wdata !== 256'h1234) begin
                errors++;
                $display("FAIL write_hold c%0d: got wr %b rd %b addr %h wdata %h required 1 0 40 1234", c, mem_write, mem_read, mem_addr, mem_wdata);
            end
            checks++;
            if (ch_rdata !== '0 || ch_resp !== (c == 3 ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL write_resp c%0d: got resp %b rdata %h", c, ch_resp, ch_rdata);
            end
        end
        step();
        mem_resp = 1'b0; mem_rdata = '0; ch_write = '0; ch_addr = '0; ch_wdata = '0;
    endtask

    task automatic test_arbitration();
        int exp_g[5];
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 2, 3, 0};
`else
        exp_g = '{0, 0, 0, 0, 0};
`endif
        apply_reset();
        ch_read = 4'b1111;
        for (int i = 0; i < NUM_CH; i++) ch_addr[i*ADDR_W +: ADDR_W] = 32'h100 * (i + 1);
        for (int n = 0; n < 5; n++) begin
            step();
            mem_resp = 1'b1;
            @(negedge clk);
            checks++;
            if (grant_ch !== 2'(exp_g[n]) || mem_addr !== 32'h100 * (exp_g[n] + 1) || ch_resp !== (4'b1 << exp_g[n])) begin
                errors++;
                $display("FAIL arb_grant n%0d: got grant %0d addr %h resp %b required %0d", n, grant_ch, mem_addr, ch_resp, exp_g[n]);
            end
            step();
            mem_resp = 1'b0;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || mem_read !== 1'b0) begin
                errors++;
                $display("FAIL arb_bubble n%0d: got busy %b rd %b required 0 0", n, busy, mem_read);
            end
        end
        ch_read = '0;
        step();
    endtask

    task automatic test_back_to_back();
        ch_read = 4'b1100;
        ch_addr[2*ADDR_W +: ADDR_W] = 32'h2222;
        ch_addr[3*ADDR_W +: ADDR_W] = 32'h3333;
        step();
        mem_resp = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_ch !== 2'd2 || mem_addr !== 32'h2222 || ch_resp !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_first: got grant %0d addr %h resp %b required 2 2222 0100", grant_ch, mem_addr, ch_resp);
        end
        step();
        mem_resp = 1'b0;
        ch_read = 4'b1000;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_bubble: got rd %b busy %b required 0 0", mem_read, busy);
        end
        step();
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || grant_ch !== 2'd3 || mem_addr !== 32'h3333) begin
            errors++;
            $display("FAIL b2b_second: got rd %b grant %0d addr %h required 1 3 3333", mem_read, grant_ch, mem_addr);
        end
        step();
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        ch_read = '0;
    endtask

    task automatic test_abandon();
        ch_read = 4'b0100;
        ch_addr[2*ADDR_W +: ADDR_W] = 32'h2000;
        step();
        ch_read = '0;
        step();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mem_read !== 1'b1 || mem_addr !== 32'h2000) begin
            errors++;
            $display("FAIL abandon_hold: got busy %b rd %b addr %h required 1 1 2000", busy, mem_read, mem_addr);
        end
        step();
        mem_resp = 1'b1;
        @(negedge clk);
        checks++;
        if (ch_resp !== 4'b0100) begin
            errors++;
            $display("FAIL abandon_resp: got %b required 0100", ch_resp);
        end
        step();
        mem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || grant_ch !== 2'd2) begin
            errors++;
            $display("FAIL abandon_done: got busy %b grant %0d required 0 2", busy, grant_ch);
        end
    endtask

    task automatic test_reset_mid_busy();
        ch_read = 4'b1000;
        step();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant_ch !== 2'd3) begin
            errors++;
            $display("FAIL midrst_pre: got busy %b grant %0d required 1 3", busy, grant_ch);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ch_read = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_read !== 1'b0 || grant_ch !== 2'd0 || ch_resp !== 4'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL midrst_post: got busy %b rd %b grant %0d resp %b required 0 0 0 0", busy, mem_read, grant_ch, ch_resp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_capture();
        test_arbitration();
        test_back_to_back();
        test_abandon();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

Parametrised N-channel arbiter that multiplexes cacheline read/write requests from several caches (I-cache, D-cache, and later L2 or prefetcher ports) onto one cacheline-adaptor port. Successor to the fixed two-port I/D arbiter. It adds:
- configurable channel count and line/address widths;
- registered capture of the winning request;
- round-robin fairness, selectable at compile time;
- a grant-ID output.

It sits between the L1 caches and the cacheline adaptor.

## Interface
Parameters:
- NUM_CH, default 2, number of requesting channels; legal range 2..8.
- ADDR_W, default 32, address width.
- LINE_W, default 256, cacheline width in bits.
- Derived: CH_W = $clog2(NUM_CH).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- ch_read  in  NUM_CH  per-channel read request.
- ch_write  in  NUM_CH  per-channel write request.
- ch_addr  in  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*LINE_W  per-channel write line; channel i occupies bits [i*LINE_W +: LINE_W].
- ch_resp  out  NUM_CH  one-hot completion pulse to the granted channel.
- ch_rdata  out  LINE_W  read line, shared by all channels; valid only when the channel's ch_resp bit is high.
- mem_read  out  1  read request to the adaptor.
- mem_write  out  1  write request to the adaptor.
- mem_addr  out  ADDR_W  request address to the adaptor.
- mem_wdata  out  LINE_W  write line to the adaptor.
- mem_resp  in  1  adaptor completion.
- mem_rdata  in  LINE_W  adaptor read line.
- busy  out  1  high while a transaction is outstanding.
- grant_ch  out  CH_W  index of the channel currently or most recently granted.

## Operation
- States: IDLE, BUSY.
- IDLE:
  - The channel is pending when ch_read[i] | ch_write[i] is set.
  - If any channel is pending, the arbitration winner g is selected.
  - On the clock edge, the block registers into op/addr/wdata registers: op = read if ch_read[g] else write, ch_addr[g], ch_wdata[g] (write only), and grant_ch <= g.
  - The state moves to BUSY.
  - If no channel is pending, the state stays IDLE.
- BUSY:
  - mem_read or mem_write (exactly one) is driven from the op register.
  - mem_addr and mem_wdata are driven from the registers, never directly from channel inputs.
  - ch_resp[grant_ch] = mem_resp, combinationally.
  - ch_rdata = mem_rdata whenever the op is a read, otherwise 0.
  - When mem_resp = 1: the state moves to IDLE and mem_read/mem_write deassert on the next cycle.
- ch_read and ch_write both high on one channel is illegal; the block treats it as a read.
- A channel that drops its request while granted does not abort the transaction. The transaction runs to mem_resp, and ch_resp still pulses.
- Requesters hold their request until they see ch_resp. A request still high in the cycle after ch_resp is treated as a new request.
- Arbitration (see Configuration):
  - Round-robin: the search starts at pointer ptr and takes the first pending channel in increasing index order, modulo NUM_CH.
  - On each grant to channel g, ptr <= (g+1) mod NUM_CH.
- Output values in IDLE and at reset:
  - mem_read, mem_write, busy, ch_resp = 0.
  - mem_addr, mem_wdata, ch_rdata = 0.
  - grant_ch = 0 and ptr = 0 at reset.
  - busy = (state == BUSY).

## Timing
- A request sampled in IDLE at edge t makes mem_* valid in cycle t+1 (1-cycle grant latency).
- mem_resp in cycle k produces ch_resp in the same cycle k, with zero added response latency.
- At edge k the state becomes IDLE. The earliest next grant is evaluated in cycle k+1, and the next mem request appears in cycle k+2 (one bubble cycle between transactions).
- If mem_resp arrives in the first BUSY cycle, the transaction is legal and completes in 1 cycle.
- Requests arriving in BUSY are held off; they are neither lost nor queued beyond the requester's own hold.
- Reset mid-transaction: the state is forced to IDLE with all outputs at reset values on the next edge. The outstanding adaptor transaction is abandoned, and the adaptor is reset in the same cycle. No ch_resp is generated.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration using ptr, as above.
  - Any continuously requesting channel is granted within NUM_CH transactions.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: the lowest pending index always wins, and ptr is not implemented.
  - The D-cache is connected to channel 0.
  - Starvation of higher indices is permitted.

## Test plan
- Single read: ch_read[1]=1, addr 0x0000_1000; mem_resp after 5 cycles with rdata 0xA5..A5 -> mem_read high cycles 1–5, mem_addr=0x1000, ch_resp=2'b10 for exactly one cycle with ch_rdata=0xA5..A5.
- Write capture: ch_write[0]=1, addr 0x40, wdata 0x1234; channel inputs changed to garbage after the grant -> mem_write/mem_addr/mem_wdata stay 1/0x40/0x1234 until mem_resp; ch_rdata=0.
- Simultaneous requests, NUM_CH=4, all four requesting continuously:
  - With the RR macro defined, the grant order is 0,1,2,3,0.
  - With it undefined, the grant order is 0,0,0…
- Back-to-back: mem_resp in cycle k with the next request pending -> mem idle in k+1, new mem_read in k+2, grant_ch updated.
- Abandon: granted channel drops ch_read mid-transaction -> transaction completes; ch_resp pulses on mem_resp.
- Reset mid-BUSY: rst high for 1 cycle -> next cycle busy=0, mem_read=0, grant_ch=0, no ch_resp.
